// File: rtl/seg7_time_reader_if.sv
// Scan-side bus of the 7-segment time reader: display scan inputs plus decoded time outputs.
interface seg7_time_reader_if;
    logic       strobe;
    logic [6:0] segIn;
    logic [5:0] digitSel;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       timeValid;
    logic       digitErr;
    logic       frameErr;

    modport master (
        output strobe, segIn, digitSel,
        input  hours, minutes, seconds, timeValid, digitErr, frameErr
    );

    modport slave (
        input  strobe, segIn, digitSel,
        output hours, minutes, seconds, timeValid, digitErr, frameErr
    );
endinterface

// File: rtl/seg7_time_reader.sv
// Reads the multiplexed 7-segment scan back into binary HH:MM:SS.
// Define SEG7_READER_TIMEOUT_EN to abort frames stalled for TIMEOUT_CYCLES.
module seg7_time_reader #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              reset_n,
    seg7_time_reader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("seg7_time_reader: TIMEOUT_CYCLES out of range");
    end

    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        case (seg)
            7'h7E:   return 5'h10;
            7'h30:   return 5'h11;
            7'h6D:   return 5'h12;
            7'h79:   return 5'h13;
            7'h33:   return 5'h14;
            7'h5B:   return 5'h15;
            7'h5F:   return 5'h16;
            7'h70:   return 5'h17;
            7'h7F:   return 5'h18;
            7'h7B:   return 5'h19;
            7'h77:   return 5'h1A;
            7'h1F:   return 5'h1B;
            7'h4E:   return 5'h1C;
            7'h3D:   return 5'h1D;
            7'h4F:   return 5'h1E;
            7'h47:   return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] units);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, units};
    endfunction

    state_t          state, state_n;
    logic [2:0]      idx, idx_n;
    logic [5:0][3:0] digits;
    logic            wr_en;
    logic [2:0]      wr_sel;
    logic            ld, derr_n, ferr_n;

    // Decode stage: the strobe edge registers pattern decode and select; the FSM acts one edge later.
    logic       stb_q;
    logic [5:0] sel_q;
    logic [4:0] code_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stb_q  <= 1'b0;
            sel_q  <= '0;
            code_q <= '0;
        end else begin
            stb_q  <= bus.strobe && (bus.digitSel != '0);
            sel_q  <= bus.digitSel;
            code_q <= seg_decode(bus.segIn);
        end
    end

    logic sel_onehot, sel_match, code_ok, range_ok;
    logic [3:0] ht, hu, mt, mu, st, su;

    assign sel_onehot = (sel_q & (sel_q - 6'd1)) == '0;
    assign sel_match  = sel_q == (6'b000001 << idx);
    assign code_ok    = code_q[4];
    assign {ht, hu, mt, mu, st, su} = digits;
    assign range_ok   = (ht <= 4'd2) && (hu <= 4'd9) && !((ht == 4'd2) && (hu > 4'd3)) &&
                        (mt <= 4'd5) && (mu <= 4'd9) && (st <= 4'd5) && (su <= 4'd9);

`ifdef SEG7_READER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      cnt <= '0;
        else if (state != COLLECT || stb_q) cnt <= '0;
        else                               cnt <= cnt + 16'd1;
    end
`endif

    always_comb begin
        state_n = state;
        idx_n   = idx;
        wr_en   = 1'b0;
        wr_sel  = idx;
        ld      = 1'b0;
        derr_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (stb_q && sel_q == 6'b100000 && code_ok) begin
                    wr_en   = 1'b1;
                    wr_sel  = 3'd5;
                    idx_n   = 3'd4;
                    state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (stb_q) begin
                    if (!sel_onehot) begin
                        ferr_n  = 1'b1;
                        state_n = IDLE;
                    end else if (!code_ok) begin
                        derr_n  = 1'b1;
                        state_n = IDLE;
                    end else if (!sel_match) begin
                        ferr_n = 1'b1;
                        if (sel_q[5]) begin
                            wr_en  = 1'b1;
                            wr_sel = 3'd5;
                            idx_n  = 3'd4;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (idx == 3'd0) state_n = CHECK;
                        else             idx_n   = idx - 3'd1;
                    end
`ifdef SEG7_READER_TIMEOUT_EN
                end else if (cnt == TO_LAST) begin
                    ferr_n  = 1'b1;
                    state_n = IDLE;
`endif
                end
            end
            CHECK: begin
                ld      = range_ok;
                ferr_n  = !range_ok;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            idx           <= '0;
            digits        <= '0;
            bus.hours     <= '0;
            bus.minutes   <= '0;
            bus.seconds   <= '0;
            bus.timeValid <= 1'b0;
            bus.digitErr  <= 1'b0;
            bus.frameErr  <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (wr_en) digits[wr_sel] <= code_q[3:0];
            if (ld) begin
                bus.hours   <= 5'(bcd2bin(ht, hu));
                bus.minutes <= 6'(bcd2bin(mt, mu));
                bus.seconds <= 6'(bcd2bin(st, su));
            end
            bus.timeValid <= ld;
            bus.digitErr  <= derr_n;
            bus.frameErr  <= ferr_n;
        end
    end
endmodule

// File: tb/tb_seg7_time_reader.sv
// Scoreboard bench for seg7_time_reader: frame-level reference model feeds an expected-event queue.
module tb_seg7_time_reader;
    localparam int TO = 8;
`ifdef SEG7_READER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int K_TV = 1, K_DE = 2, K_FE = 3, K_MULTI = 4;

    typedef struct {
        int kind;
        int t;
        int h;
        int m;
        int s;
    } ev_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    seg7_time_reader_if bus();

    seg7_time_reader #(.TIMEOUT_CYCLES(TO)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int   edge_cnt = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];
    ev_t  me;

    logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    // Reference model: digits gathered so far in the current frame and the committed time.
    bit coll = 1'b0;
    int nexp = 0;
    int dig [6];
    int last_acc = 0;
    int check_s = -1;
    int mh = 0, mm = 0, ms = 0;

    always @(posedge clock) edge_cnt = edge_cnt + 1;

    task automatic chk(input string name, input int act, input int req);
        total = total + 1;
        if (act != req) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    function automatic int seg_lookup(input logic [6:0] seg);
        for (int i = 0; i < 16; i++)
            if (seg_tab[i] == seg) return i;
        return -1;
    endfunction

    function automatic void push(input int kind, input int t);
        ev_t e;
        e.kind = kind;
        e.t    = t;
        e.h    = mh;
        e.m    = mm;
        e.s    = ms;
        exp_q.push_back(e);
    endfunction

    function automatic void do_check(input int t);
        int h, m, s;
        h = dig[5] * 10 + dig[4];
        m = dig[3] * 10 + dig[2];
        s = dig[1] * 10 + dig[0];
        if (h <= 23 && dig[4] <= 9 && dig[3] <= 5 && dig[2] <= 9 && dig[1] <= 5 && dig[0] <= 9) begin
            mh = h;
            mm = m;
            ms = s;
            push(K_TV, t);
        end else begin
            push(K_FE, t);
        end
    endfunction

    // s is the clock edge that samples this strobe.
    function automatic void model_step(input int s, input bit stb, input logic [6:0] seg,
                                       input logic [5:0] sel);
        int d;
        d = seg_lookup(seg);
        if (stb && sel != 6'b0) begin
            if (s == check_s) return;
            if (!coll) begin
                if (sel == 6'b100000 && d >= 0) begin
                    coll = 1'b1; dig[5] = d; nexp = 4; last_acc = s;
                end
            end else if ($countones(sel) != 1) begin
                push(K_FE, s + 1); coll = 1'b0;
            end else if (d < 0) begin
                push(K_DE, s + 1); coll = 1'b0;
            end else if (sel[nexp] == 1'b0) begin
                push(K_FE, s + 1);
                if (sel[5]) begin
                    dig[5] = d; nexp = 4; last_acc = s;
                end else begin
                    coll = 1'b0;
                end
            end else begin
                dig[nexp] = d;
                last_acc = s;
                if (nexp == 0) begin
                    coll = 1'b0;
                    check_s = s + 1;
                    do_check(s + 2);
                end else begin
                    nexp = nexp - 1;
                end
            end
        end else if (TO_EN && coll && (s - last_acc) == TO) begin
            push(K_FE, s + 1);
            coll = 1'b0;
        end
    endfunction

    task automatic cyc(input bit stb, input logic [6:0] seg, input logic [5:0] sel);
        int s;
        s = edge_cnt + 1;
        bus.strobe   = stb;
        bus.segIn    = seg;
        bus.digitSel = sel;
        model_step(s, stb, seg, sel);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 7'h00, 6'b0);
    endtask

    task automatic dig_at(input int p, input int v);
        cyc(1'b1, seg_tab[v], 6'(6'b000001 << p));
    endtask

    task automatic frame(input logic [23:0] b);
        for (int p = 5; p >= 0; p--) dig_at(p, int'(b[p*4 +: 4]));
    endtask

    // Monitor: every output pulse must match the head of the expected queue.
    always @(negedge clock) begin
        if (reset_n) begin
            while (exp_q.size() > 0 && exp_q[0].t < edge_cnt) begin
                me = exp_q.pop_front();
                chk("missing_pulse", 0, me.kind);
            end
            if (bus.timeValid || bus.digitErr || bus.frameErr) begin
                int got;
                if (int'(bus.timeValid) + int'(bus.digitErr) + int'(bus.frameErr) > 1) got = K_MULTI;
                else if (bus.timeValid) got = K_TV;
                else if (bus.digitErr)  got = K_DE;
                else                    got = K_FE;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", got, 0);
                end else begin
                    me = exp_q.pop_front();
                    chk("pulse_kind", got, me.kind);
                    chk("pulse_edge", edge_cnt, me.t);
                    chk("hours", int'(bus.hours), me.h);
                    chk("minutes", int'(bus.minutes), me.m);
                    chk("seconds", int'(bus.seconds), me.s);
                end
            end
        end
    end

    initial begin
        logic [23:0] b;
        int          r, hh, mi, se;
        bus.strobe   = 1'b0;
        bus.segIn    = '0;
        bus.digitSel = '0;
        repeat (3) @(negedge clock);
        chk("reset_hours", int'(bus.hours), 0);
        chk("reset_minutes", int'(bus.minutes), 0);
        chk("reset_seconds", int'(bus.seconds), 0);
        chk("reset_timeValid", int'(bus.timeValid), 0);
        chk("reset_digitErr", int'(bus.digitErr), 0);
        chk("reset_frameErr", int'(bus.frameErr), 0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        idle(2);

        frame(24'h123456);
        idle(3);
        chk("frame1_hours", int'(bus.hours), 12);
        chk("frame1_minutes", int'(bus.minutes), 34);
        chk("frame1_seconds", int'(bus.seconds), 56);

        frame(24'h235959);
        idle(2);
        frame(24'h240000);
        idle(3);
        chk("hold_hours", int'(bus.hours), 23);
        chk("hold_minutes", int'(bus.minutes), 59);
        chk("hold_seconds", int'(bus.seconds), 59);

        dig_at(5, 1); dig_at(4, 2); cyc(1'b1, 7'h00, 6'b001000);
        idle(2);
        frame(24'h012345);
        idle(3);

        dig_at(5, 1); dig_at(4, 2); dig_at(2, 3); dig_at(1, 4); dig_at(0, 5);
        idle(3);

        dig_at(5, 1); dig_at(4, 1); dig_at(3, 1);
        dig_at(5, 2); dig_at(4, 0); dig_at(3, 3); dig_at(2, 0); dig_at(1, 4); dig_at(0, 5);
        idle(3);
        chk("restart_hours", int'(bus.hours), 20);

        dig_at(5, 0); dig_at(4, 9);
        idle(TO);
        dig_at(3, 1); dig_at(2, 5); dig_at(1, 3); dig_at(0, 0);
        idle(3);

        dig_at(5, 0); cyc(1'b1, seg_tab[7], 6'b0); dig_at(4, 7); dig_at(3, 0);
        cyc(1'b1, seg_tab[3], 6'b011000);
        idle(2);
        frame(24'h111111);
        frame(24'h222222);
        idle(3);

        for (int f = 0; f < 80; f++) begin
            if ($urandom_range(0, 4) != 0) begin
                hh = $urandom_range(0, 23);
                mi = $urandom_range(0, 59);
                se = $urandom_range(0, 59);
                b = {4'(hh / 10), 4'(hh % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
            end else begin
                b = 24'($urandom);
            end
            for (int p = 5; p >= 0; p--) begin
                r = $urandom_range(0, 24);
                if (r == 0)      cyc(1'b1, 7'($urandom), 6'(6'b000001 << p));
                else if (r == 1) cyc(1'b1, seg_tab[b[p*4 +: 4]], 6'($urandom));
                else             dig_at(p, int'(b[p*4 +: 4]));
                if ($urandom_range(0, 5) == 0)
                    cyc(1'($urandom_range(0, 1)), 7'($urandom), 6'b0);
            end
            idle($urandom_range(0, 3));
        end

        idle(5);
        chk("events_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
